// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: walks n inputs/weights through a
// single multiplier and returns the weighted sum plus bias.
module neuron_mac_sequencer #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               n_inputs,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    output logic [2:0]               in_addr,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                n_lat_q, n_lat_d;
    logic [2:0]                in_addr_q, in_addr_d;
    logic                      issue_q, issue_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   result_q, result_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;

    assign prod     = in_data * w_data;
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias);

    // Next-state, address walk and accumulation; data returns one
    // cycle after its address, so issue_q marks a valid product.
    always_comb begin
        state_d   = state_q;
        n_lat_d   = n_lat_q;
        in_addr_d = in_addr_q;
        issue_d   = 1'b0;
        acc_d     = acc_q;
        result_d  = result_q;
        done_d    = 1'b0;

        if (issue_q) begin
            acc_d = acc_q + prod_ext;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_lat_d   = n_inputs;
                    acc_d     = bias_ext;
                    in_addr_d = 3'd0;
                    if (n_inputs == 3'd0) begin
                        state_d  = DONE;
                        result_d = bias_ext;
                        done_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                issue_d = 1'b1;
                if (in_addr_q == n_lat_q - 3'd1) begin
                    state_d = DRAIN;
                end else begin
                    in_addr_d = in_addr_q + 3'd1;
                end
            end
            DRAIN: begin
                state_d  = DONE;
                result_d = acc_d;
                done_d   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            n_lat_q   <= 3'd0;
            in_addr_q <= 3'd0;
            issue_q   <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_lat_q   <= n_lat_d;
            in_addr_q <= in_addr_d;
            issue_q   <= issue_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign in_addr = in_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: doc/neuron_mac_sequencer.md
NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed width of input, weight and bias words.
REQ-002 SHALL have parameter ACC_W, default 40: signed accumulator/result width.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port n_inputs  in  3  input count for this neuron, driven by the nInputs register, range 0..7.
REQ-006 SHALL have port start  in  1  single-cycle request to evaluate the neuron.
REQ-007 SHALL have port bias  in  DATA_W  signed bias, sampled with start.
REQ-008 SHALL have port in_addr  out  3  registered read index into the input and weight memories.
REQ-009 SHALL have port in_data  in  DATA_W  signed input value, valid in the cycle after in_addr is presented.
REQ-010 SHALL have port w_data  in  DATA_W  signed weight, same timing as in_data.
REQ-011 SHALL have port busy  out  1  high while a neuron evaluation is in progress.
REQ-012 SHALL have port done  out  1  single-cycle pulse marking an updated result.
REQ-013 SHALL have port result  out  ACC_W  signed weighted sum plus bias, held until the next done.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 In IDLE, start=1 SHALL latch n_inputs into n_lat, load acc with sign-extended bias, and set in_addr=0.
REQ-016 From IDLE, start with n_inputs!=0 SHALL go to RUN; start with n_inputs==0 SHALL go directly to DONE.
REQ-017 In RUN, in_addr SHALL advance by 1 each cycle, covering 0..n_lat-1 on consecutive cycles with no gaps.
REQ-018 RUN SHALL go to DRAIN in the cycle after in_addr==n_lat-1 is presented; DRAIN SHALL last exactly one cycle, then go to DONE.
REQ-019 A one-cycle-delayed issue flag SHALL qualify accumulation; acc += sign-extended in_data*w_data (full 2*DATA_W product) exactly once per issued address.
REQ-020 In DONE, result SHALL load the final acc, done SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-021 Latency: for a start sampled at edge 0, done SHALL be high in cycle n+2 for n>=1 and in cycle 1 for n=0.
REQ-022 busy SHALL be high in RUN, DRAIN and DONE, and low in IDLE.
REQ-023 start while busy SHALL be ignored, with no effect on the run in progress, and SHALL not be queued.
REQ-024 Changes to n_inputs or bias after start SHALL have no effect until the next accepted start.
REQ-025 Accumulation SHALL wrap modulo 2^ACC_W without saturation; with the default widths, 7 worst-case products plus bias cannot overflow.
REQ-026 in_addr SHALL hold its last value outside RUN; in_data and w_data SHALL be ignored except in the cycle after an issued address.
REQ-027 start in IDLE in the same cycle as a DONE→IDLE return SHALL NOT be possible; a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-028 While reset_n=0, the block SHALL be in IDLE with busy=0, done=0, in_addr=0, result=0, acc=0, n_lat=0 and the issue flag cleared, asynchronously.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after release SHALL begin a fresh evaluation.

Verification
REQ-030 Three-input evaluation: n_inputs=3, inputs {2,-3,4}, weights {5,6,-1}, bias=10 -> result=-2, done in cycle 5, in_addr 0,1,2 in cycles 1-3, busy cycles 1-5.
REQ-031 Zero-input evaluation: n_inputs=0, bias=-7, start -> result=-7, done in cycle 1, in_addr stays 0.
REQ-032 Worst-case magnitude: n_inputs=7, all in_data and w_data -32768, bias=32767 -> result=7516225535, done in cycle 9, no wrap.
REQ-033 Overlapping requests: with the REQ-030 run in progress, start pulse at cycle 2 with n_inputs changed to 5 -> run unaffected, result=-2, exactly one done.
REQ-034 Reset mid-run: reset_n low in cycle 3 of the REQ-030 run -> all outputs zero immediately, no done; a new start after release gives result=-2 with the same timing.
REQ-035 Back-to-back evaluations: second start in the cycle after done (n_inputs=1, in 3, w 4, bias 0) -> result=12, done 3 cycles later; the previous result is held in between.
